// File: rtl/operand_dispatch_if.sv
// Handshake bundle between the serial word source, the operand dispatcher
// and the merge unit. The master drives words and consumes pairs; the slave
// is the dispatcher itself.
interface operand_dispatch_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             flush;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             fast;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] pair_cnt;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, opa, opb, fast, out_valid, pair_cnt
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, opa, opb, fast, out_valid, pair_cnt
  );
endinterface

// File: rtl/operand_dispatch.sv
// Operand dispatcher: folds a serial word stream into (opa, opb) pairs,
// tags each pair with a fast qualifier taken from the top two bits of both
// operands, queues pairs in a small FIFO and issues them under valid/ready.
// The head outputs are registered and forced to zero while the FIFO is empty,
// so no stale operand data leaks to the merge unit.
module operand_dispatch #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  operand_dispatch_if.slave   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             fast;
  } pair_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] a_hold_q,    a_hold_d;
  logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [OCC_W-1:0] occ_q,       occ_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  pair_t            head_q,      head_d;
  logic             out_valid_q, out_valid_d;
  pair_t            mem_q [DEPTH];
  pair_t            mem_d [DEPTH];

  logic  full;
  logic  pop;
  logic  push;
  logic  accept;
  logic  in_ready;
  pair_t new_pair;

  // Next-state logic: word capture, FIFO push/pop, flush and head lookahead.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value unassigned and infers a latch.
    state_d     = state_q;
    a_hold_d    = a_hold_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    cnt_d       = cnt_q;
    mem_d       = mem_q;

    full     = (occ_q == OCC_W'(DEPTH));
    // A flush cycle neither accepts a word nor retires a pair.
    pop      = out_valid_q & bus.out_ready & ~bus.flush;
    // The opb word needs room for the push; a same-cycle pop frees a slot.
    in_ready = rst_n & ~bus.flush & ((state_q == WAIT_A) | ~full | pop);
    accept   = bus.in_valid & in_ready;
    push     = accept & (state_q == WAIT_B);

    new_pair.a    = a_hold_q;
    new_pair.b    = bus.in_data;
    new_pair.fast = (a_hold_q[WIDTH-1 -: 2] == 2'b00) &&
                    (bus.in_data[WIDTH-1 -: 2] == 2'b00);

    if (bus.flush) begin
      state_d  = WAIT_A;
      a_hold_d = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (accept) begin
        if (state_q == WAIT_A) begin
          a_hold_d = bus.in_data;
          state_d  = WAIT_B;
        end else begin
          state_d  = WAIT_A;
        end
      end
      if (push) begin
        mem_d[wr_ptr_q] = new_pair;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        cnt_d    = cnt_q + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end

    // Register the post-edge head so outputs are flops and zero when empty.
    out_valid_d = (occ_d != '0);
    head_d      = out_valid_d ? mem_d[rd_ptr_d] : '0;
  end

  // Control state, pointers, counter and registered head outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_A;
      a_hold_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      cnt_q       <= '0;
      head_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q     <= state_d;
      a_hold_q    <= a_hold_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Pair storage.
  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // read after it has been written, and the head register masks it otherwise.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.opa       = head_q.a;
  assign bus.opb       = head_q.b;
  assign bus.fast      = head_q.fast;
  assign bus.out_valid = out_valid_q;
  assign bus.pair_cnt  = cnt_q;

endmodule

// File: tb/tb_operand_dispatch.sv
// Directed bench for operand_dispatch. Inputs change on the falling edge and
// outputs are sampled #1 after that, well away from the rising edge.
// A second instance with a 4-bit pair counter exercises counter wrap in a
// few dozen cycles instead of 65536 pair issues.
module tb_operand_dispatch;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  operand_dispatch_if #(.WIDTH(32), .CNT_W(16)) bus   ();
  operand_dispatch_if #(.WIDTH(32), .CNT_W(4))  bus_w ();

  operand_dispatch #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  operand_dispatch #(.WIDTH(32), .DEPTH(2), .CNT_W(4)) u_dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic put_word(input logic [31:0] w);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    #1;
    while (!bus.in_ready && n < 50) begin
      next_cycle();
      #1;
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL put_word_timeout word=%h in_ready=%b need=1", w, bus.in_ready);
    end
    next_cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    bus_w.in_valid = 1'b0; bus_w.in_data = '0; bus_w.flush = 1'b0; bus_w.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({bus.opa, bus.opb, bus.fast, bus.out_valid, bus.pair_cnt, bus.in_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs opa=%h opb=%h fast=%b ov=%b cnt=%h ir=%b need all 0",
               bus.opa, bus.opb, bus.fast, bus.out_valid, bus.pair_cnt, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b need=1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    put_word(32'h1);
    put_word(32'h2);
    #1;
    total++;
    if ({bus.out_valid, bus.opa, bus.opb, bus.fast} !== {1'b1, 32'h1, 32'h2, 1'b1}) begin
      bad++;
      $display("FAIL basic_head ov=%b opa=%h opb=%h fast=%b need 1/1/2/1",
               bus.out_valid, bus.opa, bus.opb, bus.fast);
    end
    next_cycle();
    bus.out_ready = 1'b0;
    #1;
    total++;
    if ({bus.pair_cnt, bus.out_valid, bus.opa} !== {16'd1, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL basic_after_pop cnt=%0d ov=%b opa=%h need 1/0/0",
               bus.pair_cnt, bus.out_valid, bus.opa);
    end
  endtask

  task automatic test_fast();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic        vf [4];
    va[0] = 32'h4000_0000; vb[0] = 32'h0000_0005; vf[0] = 1'b0;
    va[1] = 32'h8000_0000; vb[1] = 32'h0000_0000; vf[1] = 1'b0;
    va[2] = 32'h3FFF_FFFF; vb[2] = 32'h3FFF_FFFF; vf[2] = 1'b1;
    va[3] = 32'h0000_0001; vb[3] = 32'hC000_0000; vf[3] = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put_word(va[i]);
      put_word(vb[i]);
      #1;
      total++;
      if ({bus.opa, bus.opb, bus.fast} !== {va[i], vb[i], vf[i]}) begin
        bad++;
        $display("FAIL fast_pair%0d opa=%h opb=%h fast=%b need %h/%h/%b",
                 i, bus.opa, bus.opb, bus.fast, va[i], vb[i], vf[i]);
      end
      bus.out_ready = 1'b1;
      next_cycle();
      bus.out_ready = 1'b0;
    end
    #1;
    total++;
    if (bus.pair_cnt !== 16'd5) begin
      bad++;
      $display("FAIL fast_cnt got=%0d need=5", bus.pair_cnt);
    end
  endtask

  // Covers the full-FIFO stall and the simultaneous push/pop when full.
  task automatic test_back_to_back();
    logic [31:0] exp_a [3];
    logic [31:0] exp_b [3];
    bus.out_ready = 1'b0;
    put_word(32'h11); put_word(32'h12);
    put_word(32'h21); put_word(32'h22);
    put_word(32'h31);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h32;
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.opa, bus.opb} !== {1'b0, 1'b1, 32'h11, 32'h12}) begin
      bad++;
      $display("FAIL stall_full ir=%b ov=%b opa=%h opb=%h need 0/1/11/12",
               bus.in_ready, bus.out_valid, bus.opa, bus.opb);
    end
    repeat (2) next_cycle();
    #1;
    total++;
    if ({bus.in_ready, bus.opa, bus.opb} !== {1'b0, 32'h11, 32'h12}) begin
      bad++;
      $display("FAIL stall_hold ir=%b opa=%h opb=%h need 0/11/12",
               bus.in_ready, bus.opa, bus.opb);
    end
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_push_pop_ready got=%b need=1", bus.in_ready);
    end
    next_cycle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.opa, bus.opb} !== {1'b1, 32'h21, 32'h22}) begin
      bad++;
      $display("FAIL push_pop_head ov=%b opa=%h opb=%h need 1/21/22",
               bus.out_valid, bus.opa, bus.opb);
    end
    // Occupancy must still be 2: the next opb must be refused.
    put_word(32'h41);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h42;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL occupancy_two ir=%b need=0", bus.in_ready);
    end
    bus.out_ready = 1'b1;
    next_cycle();
    bus.in_valid = 1'b0;
    exp_a[0] = 32'h31; exp_b[0] = 32'h32;
    exp_a[1] = 32'h41; exp_b[1] = 32'h42;
    exp_a[2] = 32'h0;  exp_b[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({bus.opa, bus.opb, bus.out_valid} !== {exp_a[i], exp_b[i], (i < 2) ? 1'b1 : 1'b0}) begin
        bad++;
        $display("FAIL drain%0d opa=%h opb=%h ov=%b need %h/%h/%b",
                 i, bus.opa, bus.opb, bus.out_valid, exp_a[i], exp_b[i], (i < 2));
      end
      next_cycle();
    end
    bus.out_ready = 1'b0;
    #1;
    total++;
    if (bus.pair_cnt !== 16'd9) begin
      bad++;
      $display("FAIL drain_cnt got=%0d need=9", bus.pair_cnt);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    put_word(32'hA);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hEE;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_ready got=%b need=0", bus.in_ready);
    end
    next_cycle();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    put_word(32'hB);
    put_word(32'hC);
    #1;
    total++;
    if ({bus.out_valid, bus.opa, bus.opb} !== {1'b1, 32'hB, 32'hC}) begin
      bad++;
      $display("FAIL flush_partial ov=%b opa=%h opb=%h need 1/b/c",
               bus.out_valid, bus.opa, bus.opb);
    end
    bus.out_ready = 1'b1;
    next_cycle();
    bus.out_ready = 1'b0;
    // A queued pair is dropped by flush without being counted as issued.
    put_word(32'hD);
    put_word(32'hE);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    next_cycle();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.opa, bus.pair_cnt} !== {1'b0, 32'h0, 16'd10}) begin
      bad++;
      $display("FAIL flush_fifo ov=%b opa=%h cnt=%0d need 0/0/10",
               bus.out_valid, bus.opa, bus.pair_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    int n;
    bus_w.in_valid  = 1'b1;
    bus_w.out_ready = 1'b1;
    bus_w.in_data   = 32'h100;
    n = 0;
    while (bus_w.pair_cnt !== 4'hF && n < 200) begin
      next_cycle();
      bus_w.in_data = bus_w.in_data + 32'h1;
      n++;
    end
    total++;
    if (bus_w.pair_cnt !== 4'hF) begin
      bad++;
      $display("FAIL wrap_reach_max got=%h need=f", bus_w.pair_cnt);
    end
    n = 0;
    while (bus_w.pair_cnt === 4'hF && n < 10) begin
      next_cycle();
      n++;
    end
    bus_w.in_valid  = 1'b0;
    bus_w.out_ready = 1'b0;
    total++;
    if (bus_w.pair_cnt !== 4'h0) begin
      bad++;
      $display("FAIL wrap_to_zero got=%h need=0", bus_w.pair_cnt);
    end
  endtask

  task automatic test_reset_mid_pair();
    bus.out_ready = 1'b0;
    put_word(32'h61);
    put_word(32'h62);
    put_word(32'h51);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.opa, bus.opb, bus.fast, bus.out_valid, bus.pair_cnt, bus.in_ready} !== '0) begin
      bad++;
      $display("FAIL async_reset opa=%h opb=%h fast=%b ov=%b cnt=%h ir=%b need all 0",
               bus.opa, bus.opb, bus.fast, bus.out_valid, bus.pair_cnt, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    put_word(32'h71);
    put_word(32'h72);
    #1;
    total++;
    if ({bus.out_valid, bus.opa, bus.opb} !== {1'b1, 32'h71, 32'h72}) begin
      bad++;
      $display("FAIL reset_drops_opa ov=%b opa=%h opb=%h need 1/71/72",
               bus.out_valid, bus.opa, bus.opb);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_fast();
    test_back_to_back();
    test_flush();
    test_cnt_wrap();
    test_reset_mid_pair();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
